// File: rtl/hex_scan_if.sv
// rtl/hex_scan_if.sv - value/display bundle between a producer and the hex_scan driver
interface hex_scan_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  lz;
  logic [DIGITS-1:0]     blink_mask;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame;

  // Producer side: drives value and display controls, watches the pins.
  modport master (
    output load, value, dp_in, lz, blink_mask,
    input  seg, dp, an, frame
  );

  // Driver side.
  modport slave (
    input  load, value, dp_in, lz, blink_mask,
    output seg, dp, an, frame
  );
endinterface

// File: rtl/hex_scan.sv
// rtl/hex_scan.sv - multiplexed hex seven-segment driver with tear-free updates
module hex_scan #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  hex_scan_if.slave   bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(DIGITS - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(BLINK_DIV - 1);

  logic [CW-1:0]         cnt;
  logic [KW-1:0]         k;
  logic [BW-1:0]         bcnt;
  logic                  phase;
  logic [4*DIGITS-1:0]   shadow;
  logic [4*DIGITS-1:0]   active;
  logic [DIGITS-1:0]     dp_shadow;
  logic [DIGITS-1:0]     dp_active;
  logic                  pending;

  logic                  frame_end;
  logic [3:0]            nib;
  logic                  dp_req;
  logic                  lz_blank;
  logic                  blink_on;
  logic [DIGITS:0]       zero_above;

  // Hex digit to active-low gfedcba pattern.
  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction

  assign frame_end = (cnt == CNT_LAST) && (k == K_LAST);

  // Slot prescaler and digit index; the index advances as the prescaler wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      k   <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      k   <= (k == K_LAST) ? '0 : k + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Blink half-period timer; phase=1 is the dark half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == B_LAST) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  // Double buffer: loads land in the shadow, commits happen only at the end of
  // the last slot so a frame never mixes old and new digits. A load on the
  // commit edge itself bypasses the shadow so it is not delayed a whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      dp_shadow <= '0;
      active    <= '0;
      dp_active <= '0;
      pending   <= 1'b0;
      bus.frame <= 1'b0;
    end else begin
      bus.frame <= 1'b0;
      if (bus.load) begin
        shadow    <= bus.value;
        dp_shadow <= bus.dp_in;
        pending   <= 1'b1;
      end
      if (frame_end && (pending || bus.load)) begin
        active    <= bus.load ? bus.value : shadow;
        dp_active <= bus.load ? bus.dp_in : dp_shadow;
        pending   <= 1'b0;
        bus.frame <= 1'b1;
      end
    end
  end

  // zero_above[i] is set when every active nibble from i upward is zero.
  always_comb begin
    zero_above[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above[i] = zero_above[i+1] && (active[4*i +: 4] == 4'h0);
    end
  end

  // Select the current digit's nibble, dp request and blanking conditions.
  always_comb begin
    nib      = 4'h0;
    dp_req   = 1'b0;
    lz_blank = 1'b0;
    blink_on = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (k == KW'(i)) begin
        nib      = active[4*i +: 4];
        dp_req   = dp_active[i];
        blink_on = phase && bus.blink_mask[i];
        if (i != 0) lz_blank = bus.lz && zero_above[i];
      end
    end
  end

  // Registered pins; the first cycle of every slot is dark so the previous
  // digit's segments do not ghost onto the next anode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.seg <= 7'h7F;
      bus.dp  <= 1'b1;
      bus.an  <= '1;
    end else if (cnt == '0) begin
      bus.seg <= 7'h7F;
      bus.dp  <= 1'b1;
      bus.an  <= '1;
    end else begin
      bus.an  <= ~(DIGITS'(1) << k);
      bus.seg <= (lz_blank || blink_on) ? 7'h7F : font(nib);
      bus.dp  <= blink_on ? 1'b1 : ~dp_req;
    end
  end
endmodule

// File: doc/hex_scan.md
# hex_scan

Parametrised multiplexed hexadecimal display driver for the board's common-anode seven-segment digits. It holds a DIGITS-wide nibble vector, scans one digit per slot with a one-cycle anti-ghost blanking guard, and applies leading-zero suppression, per-digit decimal points and per-digit blinking. Updates are double-buffered and committed only at frame boundaries, so a displayed frame never mixes old and new digits. It sits between any value producer (counters, PS/2 scancode capture) and the board's segment and anode pins.

## Interface
- DIGITS, 4: number of digits, 1..8.
- SCAN_DIV, 1000: clocks per digit slot, ≥2.
- BLINK_DIV, 25000000: clocks per blink half-period, ≥1.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe that captures value and dp_in into the shadow registers.
- value  in  4*DIGITS  nibble k in [4k+3:4k]; k=0 is the rightmost, least-significant digit.
- dp_in  in  DIGITS  decimal point request per digit (1 = lit).
- lz  in  1  leading-zero suppression enable, sampled live.
- blink_mask  in  DIGITS  per-digit blink enable, sampled live.
- seg  out  7  active-low segments, bit order gfedcba (seg[6]=g … seg[0]=a), registered.
- dp  out  1  active-low decimal point, registered.
- an  out  DIGITS  active-low digit enables, registered; at most one bit low.
- frame  out  1  one-cycle pulse on every frame boundary at which a commit occurred.

## Operation
- **State:** prescaler cnt (0..SCAN_DIV-1), slot index k (0..DIGITS-1), shadow/active value and dp registers, pending flag, blink counter and blink phase.
- **Scan:** cnt increments every clock. At cnt==SCAN_DIV-1, cnt wraps to 0 and k increments, wrapping DIGITS-1→0.
- **Output register:** each edge loads from the pre-edge cnt and k.
  - cnt==0 (guard): an=all 1, seg=7F, dp=1.
  - Otherwise: an=~(1<<k), seg=font(active[k]) unless blanked, dp=~dp_active[k] unless blink-blanked.
- **Font** (hex digit = seg value): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- **Leading-zero blank:** with lz=1, digit k>0 is blanked (seg=7F) when active nibbles k..DIGITS-1 are all zero. Digit 0 is never suppressed. The dp is unaffected by leading-zero blanking.
- **Blink:** the blink counter wraps at BLINK_DIV-1 and toggles the phase. When phase=1, digits with blink_mask[k]=1 show seg=7F and dp=1; their an bit still asserts.
- **Load:** shadow←value, dp_shadow←dp_in, pending←1.
- **Commit:** on the edge where cnt==SCAN_DIV-1, k==DIGITS-1 and pending=1:
  - active←shadow, pending←0;
  - frame=1 for the following cycle.
  - With no pending data there is no commit and frame stays 0.
- **Simultaneous load and commit edge:** active takes the new value and dp_in directly, pending ends 0, and frame pulses.
- **Load while pending:** the shadow is overwritten; only the last load before the boundary is shown.

## Timing
- **Reset values:** seg=7F, dp=1, an=all 1, frame=0, cnt=0, k=0, all value registers 0, pending=0, blink counter 0, phase=0.
- **After reset release:**
  - First edge is a guard cycle (cnt was 0).
  - Digit 0 is driven from the second edge for SCAN_DIV-1 cycles.
  - Each slot then continues as one guard cycle plus SCAN_DIV-1 drive cycles.
- **Frame period:** DIGITS*SCAN_DIV cycles.
- **Load-to-display latency:** at most DIGITS*SCAN_DIV+1 cycles, at least 2.
- **Live inputs:** lz and blink_mask changes take effect at the next output register update (1 cycle).
- **Reset mid-scan:** all outputs return to reset values immediately (asynchronous), and the pending load is discarded.

## Test plan
Use DIGITS=4, SCAN_DIV=4, BLINK_DIV=64.
- **Reset and scan:** assert rst → seg=7F, an=F, dp=1. Release, load 0x1234 with dp_in=0 → frame pulses at the first boundary. The next frame shows:
  - an=E with seg=19;
  - an=D with seg=30;
  - an=B with seg=24;
  - an=7 with seg=79;
  - each for 3 cycles, separated by 1-cycle an=F guards.
- **Font sweep:** load each nibble 0..F into digit 0 → seg matches the font list exactly.
- **Leading-zero suppression, lz=1:**
  - value 0x0050 → digits 3 and 2 show 7F, digit 1 shows 12, digit 0 shows 40.
  - value 0x0000 → only digit 0 shows 40.
  - With lz=0, all digits show 40.
- **Tear-free update:** load 0xAAAA mid-frame after 0x5555 is displayed → the remainder of the frame still shows 12, and the next frame shows 08. A load on the commit edge itself is displayed in the next frame.
- **Blink:** blink_mask=0001 and dp_in=0001 → digit 0 seg/dp alternate between lit and off every 64 cycles, while digits 1–3 are unaffected.
- **Reset mid-operation:** pulse rst mid-slot with a pending load → outputs return to reset values immediately. After release the display shows zeros and frame does not pulse.
